// File: rtl/skid_flop_stage.sv
// skid_flop_stage: two-entry elastic pipeline register with valid/ready on
// both sides and a synchronous flush. The main register always drives
// out_data; the skid register catches the one extra word that can arrive
// while the consumer stalls, so in_ready never depends on out_ready
// combinationally.
module skid_flop_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // State value equals the number of held words.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic             w_flush;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_ld_main_in;
  logic             w_ld_main_skid;
  logic             w_ld_skid;

  assign w_flush    = reset | clear;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // State register: flush returns to EMPTY, otherwise follow the next-state logic.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and register-load decisions from the two handshakes.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt  = ST_HALF;
          w_ld_main_in = 1'b1;
        end
      end
      ST_HALF: begin
        if (w_in_xfer && w_out_xfer) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the consumer can move things.
        if (w_out_xfer) begin
          w_state_nxt    = ST_HALF;
          w_ld_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Data registers: zeroed on flush, loaded only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= in_data;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= in_data;
      end
    end
  end

  // Handshake outputs: only reset/clear reach them combinationally.
  always_comb begin
    in_ready  = (r_state != ST_FULL) & ~clear & ~reset;
    out_valid = (r_state != ST_EMPTY) & ~clear & ~reset;
    count     = r_state;
    out_data  = r_main;
  end

endmodule

// File: tb/tb_skid_flop_stage.sv
// Testbench for skid_flop_stage: directed vector table followed by a
// randomized soak against a queue reference model.
module tb_skid_flop_stage;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int n_cmp;
  int n_bad;

  skid_flop_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs held for a cycle, outputs expected in that same cycle
  // (before the closing posedge).
  typedef struct {
    logic             rst;
    logic             clr;
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             ir;
    logic             ov;
    logic             chk_od;
    logic [WIDTH-1:0] od;
    logic [1:0]       cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic clr, input logic iv,
                              input logic [WIDTH-1:0] d, input logic ordy,
                              input logic ir, input logic ov, input logic chk_od,
                              input logic [WIDTH-1:0] od, input logic [1:0] cnt);
    vec_t v;
    v.rst = rst; v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.chk_od = chk_od; v.od = od; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] q[$];
    logic             m_ir;
    logic             m_ov;
    logic             r_iv;
    logic             r_or;
    logic             r_cl;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //   rst clr iv  d      ordy ir  ov  chk od     cnt
    // reset
    add(1, 0, 0, 8'h00, 0,  0, 0, 1, 8'h00, 0);
    add(1, 0, 0, 8'h00, 0,  0, 0, 1, 8'h00, 0);
    // steady flow
    add(0, 0, 1, 8'h01, 1,  1, 0, 1, 8'h00, 0);
    add(0, 0, 1, 8'h02, 1,  1, 1, 1, 8'h01, 1);
    add(0, 0, 1, 8'h03, 1,  1, 1, 1, 8'h02, 1);
    add(0, 0, 0, 8'h00, 1,  1, 1, 1, 8'h03, 1);
    // backpressure fill
    add(0, 0, 1, 8'hA1, 0,  1, 0, 0, 8'h00, 0);
    add(0, 0, 1, 8'hA2, 0,  1, 1, 1, 8'hA1, 1);
    add(0, 0, 1, 8'hA3, 0,  0, 1, 1, 8'hA1, 2);
    add(0, 0, 1, 8'hA3, 0,  0, 1, 1, 8'hA1, 2);
    // drain from FULL
    add(0, 0, 1, 8'hA3, 1,  0, 1, 1, 8'hA1, 2);
    add(0, 0, 1, 8'hA3, 1,  1, 1, 1, 8'hA2, 1);
    add(0, 0, 0, 8'h00, 1,  1, 1, 1, 8'hA3, 1);
    add(0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0);
    // clear while FULL
    add(0, 0, 1, 8'h55, 0,  1, 0, 0, 8'h00, 0);
    add(0, 0, 1, 8'h66, 0,  1, 1, 1, 8'h55, 1);
    add(0, 1, 1, 8'h77, 1,  0, 0, 1, 8'h55, 2);
    add(0, 0, 0, 8'h00, 1,  1, 0, 1, 8'h00, 0);
    add(0, 0, 1, 8'h88, 0,  1, 0, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  1, 1, 1, 8'h88, 1);
    // reset mid-stream
    add(0, 0, 1, 8'h3C, 0,  1, 0, 0, 8'h00, 0);
    add(1, 0, 1, 8'hFF, 1,  0, 0, 1, 8'h3C, 1);
    add(1, 0, 0, 8'h00, 0,  0, 0, 1, 8'h00, 0);
    add(0, 0, 1, 8'h11, 0,  1, 0, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1,  1, 1, 1, 8'h11, 1);
    add(0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      clear     = vecs[i].clr;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      #2;
      check("in_ready",  i, 32'(in_ready),  32'(vecs[i].ir));
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
      check("count",     i, 32'(count),     32'(vecs[i].cnt));
      if (vecs[i].chk_od) begin
        check("out_data", i, 32'(out_data), 32'(vecs[i].od));
      end
    end

    // Random soak; state is EMPTY after the last table row.
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      r_iv = ($urandom_range(0, 3) != 0);
      r_or = ($urandom_range(0, 2) != 0);
      r_cl = ($urandom_range(0, 199) == 0);
      reset     = 1'b0;
      clear     = r_cl;
      in_valid  = r_iv;
      in_data   = WIDTH'($urandom);
      out_ready = r_or;
      m_ir = (q.size() < 2) && !r_cl;
      m_ov = (q.size() > 0) && !r_cl;
      #2;
      check("soak_in_ready",  c, 32'(in_ready),  32'(m_ir));
      check("soak_out_valid", c, 32'(out_valid), 32'(m_ov));
      check("soak_count",     c, 32'(count),     32'(q.size()));
      if (m_ov) begin
        check("soak_out_data", c, 32'(out_data), 32'(q[0]));
      end
      @(posedge clk);
      if (r_cl) begin
        q.delete();
      end else begin
        if (m_ov && r_or) void'(q.pop_front());
        if (m_ir && r_iv) q.push_back(in_data);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
